serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have one clock and one synchronous active-high reset, named as below.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 SHALL have port clear  input  1  synchronous active-high reset.
REQ-004 SHALL have port si  input  1  serial line from upstream shift-register so; idles at 0.
REQ-005 SHALL have port ready  input  1  downstream accepts data_out when high.
REQ-006 SHALL have port data_out  output  8  received byte.
REQ-007 SHALL have port valid  output  1  data_out/parity_err hold a byte not yet accepted.
REQ-008 SHALL have port parity_err  output  1  parity flag for the byte in data_out.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  sticky; a good frame was dropped because the buffer was full.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 SHALL receive an 11-bit frame at one bit per clk edge: start (1), 8 data bits MSB first, even-parity bit, stop (0).
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY, STOP; state encoding free.
REQ-014 IDLE: si=1 at an edge -> DATA with bit counter=0; si=0 -> stay IDLE.
REQ-015 DATA: each edge shifts si into an 8-bit shift register (data <= {data[6:0], si}); after the 8th data bit -> PARITY.
REQ-016 PARITY: SHALL sample si as parity bit; error when XOR of 8 data bits and parity bit is 1; -> STOP.
REQ-017 STOP: si=0 -> good frame, offered to output buffer; si=1 -> frame_err=1 for exactly the next cycle, byte discarded, buffer untouched; -> IDLE in both cases.
REQ-018 A 1 sampled as a bad stop bit SHALL NOT be treated as a start bit.
REQ-019 Latency: start sampled at edge N; valid=1 and data_out valid after edge N+10.
REQ-020 Earliest next start bit SHALL be sampled at edge N+11 (back-to-back frames supported with no idle gap).
REQ-021 Output buffer is one entry; transfer occurs at an edge where valid=1 and ready=1.
REQ-022 On transfer with no simultaneous good frame, valid SHALL drop to 0 after that edge.
REQ-023 Good frame when valid=0, or valid=1 and ready=1 at same edge: load data_out and parity_err, valid=1.
REQ-024 Good frame when valid=1 and ready=0: byte dropped, buffer unchanged, overrun set to 1 and held until clear.
REQ-025 data_out and parity_err SHALL be stable while valid=1 and ready=0.
REQ-026 parity_err SHALL NOT suppress delivery; byte is delivered with parity_err=1.
REQ-027 busy SHALL be 1 in DATA, PARITY, STOP; 0 in IDLE.
REQ-028 ready has no effect on the FSM; reception continues regardless of backpressure.

Reset
REQ-029 clear=1 at an edge SHALL force IDLE, shift register and counter 0, data_out=8'h00, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-030 clear SHALL override all other inputs, including a start bit or transfer at the same edge.
REQ-031 clear mid-frame SHALL abandon the frame; no valid, frame_err or overrun results from it.
REQ-032 Before the first clear, output values are unspecified; bench SHALL apply clear first.

Verification
REQ-033 ready=1, si = 1,1,0,1,0,0,1,0,1,0,0 (start, 0xA5, parity 0, stop 0) -> after 11th edge data_out=8'hA5, valid=1, parity_err=0; valid=0 one edge later.
REQ-034 Frame data 0x01, parity bit 0, stop 0 -> data_out=8'h01, valid=1, parity_err=1.
REQ-035 Frame 0x3C, parity 0, stop 1 -> frame_err=1 for one cycle, valid stays 0, FSM IDLE next cycle, busy=0.
REQ-036 ready=0, two back-to-back good frames 0x11 then 0x22 -> data_out holds 8'h11, valid=1, overrun=1; raise ready -> one transfer, valid=0, overrun stays 1 until clear.
REQ-037 ready=1, back-to-back frames 0x5A then 0xC3 with no gap -> valid pulses at edges N+10 and N+21, data 8'h5A then 8'hC3.
REQ-038 clear=1 at 5th data bit of a frame, then si=0 -> all outputs zero, busy=0, no valid or frame_err afterward.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receives an 11-bit serial frame at one bit per clock:
//   start(1), 8 data bits MSB first, even-parity bit, stop(0).
//   Good frames go into a one-entry output buffer drained by a
//   valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high reset
//   si         in   serial line, idles at 0
//   ready      in   downstream accepts data_out when high
//   data_out   out  [7:0] received byte
//   valid      out  buffer holds a byte not yet accepted
//   parity_err out  parity flag for the byte in data_out
//   frame_err  out  one-cycle pulse after a bad stop bit
//   overrun    out  sticky: a good frame was dropped, buffer was full
//   busy       out  high whenever the FSM is not IDLE
module serial_frame_rx (
    input  logic       clk,
    input  logic       clear,
    input  logic       si,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [7:0] shreg_q;
    logic       perr_q;        // parity result of the frame in flight
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_out_q;    // parity flag of the buffered byte
    logic       frame_err_q;
    logic       overrun_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            perr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_out_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // Transfer empties the buffer; a good frame completing on the
            // same edge reloads it below (later assignment wins).
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (si) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end
                DATA: begin
                    shreg_q <= {shreg_q[6:0], si};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= PARITY;
                    end
                end
                PARITY: begin
                    perr_q  <= ^{shreg_q, si};
                    state_q <= STOP;
                end
                STOP: begin
                    // Always return to IDLE: a bad stop bit of 1 is never
                    // taken as the next start bit.
                    state_q <= IDLE;
                    if (si) begin
                        frame_err_q <= 1'b1;
                    end else if (!valid_q || ready) begin
                        data_q     <= shreg_q;
                        perr_out_q <= perr_q;
                        valid_q    <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Scoreboard bench for serial_frame_rx. Expected {parity_err, byte}
//   entries are queued when a frame is driven and compared when the
//   DUT hands a byte over (valid && ready).
module tb_serial_frame_rx;

    logic       clk;
    logic       clear;
    logic       si;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned checks;
    int unsigned errors;
    logic [8:0]  exp_q[$];

    serial_frame_rx dut (
        .clk       (clk),
        .clear     (clear),
        .si        (si),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit and advance past the edge that samples it.
    task automatic send_bit(input logic b);
        si = b;
        @(posedge clk);
        #1;
    endtask

    // Full frame; returns #1 after the edge that samples the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        logic [7:0] dd;
        dd = d;
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(dd[i]);
        send_bit(p);
        send_bit(stop);
        si = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        si = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {24'h0, data_out}, 32'h0);
        check({tag, "_valid"}, {31'h0, valid}, 32'h0);
        check({tag, "_perr"}, {31'h0, parity_err}, 32'h0);
        check({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
        check({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Output monitor: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (!clear && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("xfer_data", {24'h0, data_out}, {24'h0, e[7:0]});
                check("xfer_perr", {31'h0, parity_err}, {31'h0, e[8]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        checks = 0;
        errors = 0;
        clear  = 1'b1;
        si     = 1'b0;
        ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        clear = 1'b0;

        // 0xA5, parity 0, good stop
        ready = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0);
        check("a5_valid", {31'h0, valid}, 32'd1);
        check("a5_data", {24'h0, data_out}, 32'hA5);
        check("a5_perr", {31'h0, parity_err}, 32'd0);
        check("a5_busy", {31'h0, busy}, 32'd0);
        idle(1);
        check("a5_valid_drop", {31'h0, valid}, 32'd0);

        // 0x01 with parity 0 -> parity error, still delivered
        ready = 1'b0;
        exp_q.push_back({1'b1, 8'h01});
        send_frame(8'h01, 1'b0, 1'b0);
        check("p01_valid", {31'h0, valid}, 32'd1);
        check("p01_data", {24'h0, data_out}, 32'h01);
        check("p01_perr", {31'h0, parity_err}, 32'd1);
        ready = 1'b1;
        idle(1);
        check("p01_valid_drop", {31'h0, valid}, 32'd0);

        // 0x3C with bad stop bit
        send_frame(8'h3C, 1'b0, 1'b1);
        check("fe_pulse", {31'h0, frame_err}, 32'd1);
        check("fe_valid", {31'h0, valid}, 32'd0);
        check("fe_busy", {31'h0, busy}, 32'd0);
        idle(1);
        check("fe_pulse_end", {31'h0, frame_err}, 32'd0);
        check("fe_busy2", {31'h0, busy}, 32'd0);

        // Backpressure: 0x11 then 0x22 back to back, second dropped
        ready = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b0);
        check("ov_first_ovr", {31'h0, overrun}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b0);
        check("ov_valid", {31'h0, valid}, 32'd1);
        check("ov_data", {24'h0, data_out}, 32'h11);
        check("ov_ovr", {31'h0, overrun}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("ov_hold_data", {24'h0, data_out}, 32'h11);
            check("ov_hold_valid", {31'h0, valid}, 32'd1);
        end
        ready = 1'b1;
        idle(1);
        check("ov_drain_valid", {31'h0, valid}, 32'd0);
        check("ov_sticky", {31'h0, overrun}, 32'd1);
        idle(2);
        check("ov_sticky2", {31'h0, overrun}, 32'd1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_all_zero("ov_clear");

        // Back-to-back 0x5A, 0xC3 with ready high
        ready = 1'b1;
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'h5A, 1'b0, 1'b0);
        check("b2b_v1", {31'h0, valid}, 32'd1);
        check("b2b_d1", {24'h0, data_out}, 32'h5A);
        send_bit(1'b1);
        check("b2b_v1_drop", {31'h0, valid}, 32'd0);
        check("b2b_busy", {31'h0, busy}, 32'd1);
        d = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(1'b0);
        check("b2b_v2_early", {31'h0, valid}, 32'd0);
        send_bit(1'b0);
        si = 1'b0;
        check("b2b_v2", {31'h0, valid}, 32'd1);
        check("b2b_d2", {24'h0, data_out}, 32'hC3);
        idle(1);

        // Random frames, random parity, random gaps
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            exp_q.push_back({^d ^ p, d});
            send_frame(d, p, 1'b0);
            check("rnd_valid", {31'h0, valid}, 32'd1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        check("rnd_ovr", {31'h0, overrun}, 32'd0);

        // clear in the middle of a frame
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        si = 1'b0;
        check_all_zero("midclr");
        for (int i = 0; i < 12; i++) begin
            idle(1);
            check("midclr_valid", {31'h0, valid}, 32'd0);
            check("midclr_ferr", {31'h0, frame_err}, 32'd0);
            check("midclr_busy", {31'h0, busy}, 32'd0);
        end
        check("midclr_ovr", {31'h0, overrun}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
